// File: rtl/shift_add_multiplier.sv
// Sequential unsigned W x W shift-and-add multiplier driving an external ripple-carry adder.
// One add-and-shift iteration per clock; the product is held until the next completion.
module shift_add_multiplier #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_cin,
  input  logic [W-1:0]   add_s,
  input  logic           add_cout
);

  localparam int unsigned CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   m;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic [CW-1:0]  cnt;
  logic           last;
  logic [2*W-1:0] shifted;

  assign last = (cnt == CW'(W - 1));

  // Full W+1 bit sum is kept: carry becomes the new MSB after the right shift.
  assign shifted = {add_cout, add_s, lo[W-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Adder operands and done decode; operands come from registers only
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    done    = 1'b0;
    case (state)
      RUN: begin
        add_a = hi;
        add_b = lo[0] ? m : '0;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, iteration, product latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '0;
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
      p   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= mcand;
            hi  <= '0;
            lo  <= mplier;
            cnt <= '0;
          end
        end
        RUN: begin
          {hi, lo} <= shifted;
          cnt      <= cnt + CW'(1);
          if (last) p <= shifted;
        end
        default: ;
      endcase
    end
  end

  // Busy is registered and tracks entry into RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: bench-side CPA, cycle-timeline product model, directed vectors.
module tb_shift_add_multiplier;

  localparam int W  = 4;
  localparam int SW = W + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_s;
  logic           add_cout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  shift_add_multiplier #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .p(p), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // Combinational ripple-carry adder the multiplier is wired around
  assign {add_cout, add_s} = SW'(add_a) + SW'(add_b) + SW'(add_cin);

  always @(posedge clk) cyc <= cyc + 1;

  // Model: phase counts cycles since acceptance; product is plain multiplication
  int             phase;
  logic [2*W-1:0] m_p;
  logic [2*W-1:0] pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0;
      m_p   <= '0;
      pend  <= '0;
    end else if (phase == 0) begin
      if (start) begin
        pend  <= (2*W)'(mcand) * (2*W)'(mplier);
        phase <= 1;
      end
    end else if (phase <= W) begin
      if (phase == W) m_p <= pend;
      phase <= phase + 1;
    end else begin
      phase <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(phase >= 1 && phase <= W));
      chk("done", 32'(done), 32'(phase == W + 1));
      chk("p", 32'(p), 32'(m_p));
      chk("add_cin", 32'(add_cin), 32'd0);
      if (phase == 0) begin
        chk("idle_add_a", 32'(add_a), 32'd0);
        chk("idle_add_b", 32'(add_b), 32'd0);
      end
    end
  end

  task automatic wait_done(output int nb, output int at);
    nb = 0;
    at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
      if (busy) nb++;
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within 30 cycles");
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string nm);
    int nb, at;
    @(posedge clk); #2;
    mcand = a; mplier = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(nb, at);
    chk({nm, "_p"}, 32'(p), 32'(exp));
    chk({nm, "_busy_cycles"}, 32'(nb), 32'd4);
  endtask

  task automatic no_extra_done(input string nm);
    int extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk(nm, 32'(extra), 32'd0);
  endtask

  initial begin
    int nb, t1, t2;
    rst_n = 1'b0; start = 1'b0; mcand = '0; mplier = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_p", 32'(p), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op(4'd3, 4'd5, 8'h0F, "t1_3x5");
    chk("t1_model_p", 32'(m_p), 32'h0F);
    run_op(4'd15, 4'd15, 8'hE1, "t2_15x15");
    chk("t2_model_p", 32'(m_p), 32'hE1);
    run_op(4'd9, 4'd0, 8'h00, "t3_9x0");
    run_op(4'd0, 4'd13, 8'h00, "t3_0x13");

    // Start held high: two back-to-back products
    @(posedge clk); #2;
    mcand = 4'd7; mplier = 4'd6; start = 1'b1;
    @(posedge clk); #2;
    mcand = 4'd11; mplier = 4'd2;
    wait_done(nb, t1);
    chk("t4_first_p", 32'(p), 32'd42);
    chk("t4_first_busy_cycles", 32'(nb), 32'd4);
    wait_done(nb, t2);
    start = 1'b0;
    chk("t4_second_p", 32'(p), 32'd22);
    chk("t4_done_spacing", 32'(t2 - t1), 32'd6);

    // Operand change and START pulse during RUN are ignored
    @(posedge clk); @(posedge clk); #2;
    mcand = 4'd14; mplier = 4'd3; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    mcand = 4'd1; mplier = 4'd1; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(nb, t1);
    chk("t5_p", 32'(p), 32'h2A);
    no_extra_done("t5_single_done");

    // Reset mid-run aborts
    @(posedge clk); #2;
    mcand = 4'd12; mplier = 4'd12; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_abort_busy", 32'(busy), 32'd0);
    chk("t6_abort_p", 32'(p), 32'd0);
    chk("t6_abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    no_extra_done("t6_no_done_after_abort");
    run_op(4'd2, 4'd2, 8'd4, "t6_2x2");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
